// File: rtl/csi_pkg.sv
// Shared constants, header struct and FSM encoding for the CSI-2 packet header decoder.
// COL[i] is the syndrome a single flip of header data bit i produces.
package csi_pkg;

    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam logic [5:0] COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_H1, ST_H2, ST_H3, ST_PAYLOAD, ST_CRC
    } state_t;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } hdr_t;

    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 24; i++)
            if (d[i]) p = p ^ COL[i];
        return p;
    endfunction

endpackage

// File: rtl/csi_ecc_correct.sv
// Combinational CSI-2 header ECC check: fixes any single-bit error in data or ECC,
// flags everything else as uncorrectable.
module csi_ecc_correct
    import csi_pkg::*;
(
    input  logic [23:0] i_d,
    input  logic [5:0]  i_ecc,
    output logic [23:0] o_d,
    output logic        o_corrected,
    output logic        o_uncorrectable
);

    logic [5:0] w_syn;
    logic       w_hit;

    assign w_syn = i_ecc ^ ecc_calc(i_d);

    always_comb begin
        o_d             = i_d;
        w_hit           = 1'b0;
        o_corrected     = 1'b0;
        o_uncorrectable = 1'b0;
        if (w_syn != 6'h00) begin
            for (int i = 0; i < 24; i++) begin
                if (w_syn == COL[i]) begin
                    o_d[i] = ~i_d[i];
                    w_hit  = 1'b1;
                end
            end
            // A one-hot syndrome means the ECC bit itself flipped; data is fine.
            if ($onehot(w_syn)) w_hit = 1'b1;
            o_corrected     = w_hit;
            o_uncorrectable = ~w_hit;
        end
    end

endmodule

// File: rtl/csi_header_decoder.sv
// CSI-2 packet header capture/decode, payload forwarding and CRC drop.
// Pulses packet_done so the lane aligner re-hunts for the next sync.
module csi_header_decoder
    import csi_pkg::*;
#(
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        packet_start,
    output logic        hdr_valid,
    output logic [1:0]  hdr_vc,
    output logic [5:0]  hdr_dt,
    output logic [15:0] hdr_wc,
    output logic        hdr_corrected,
    output logic        hdr_error,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic        packet_done,
    output logic        pkt_abort
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_crc, w_crc_nxt;
    logic [7:0]  r_b0, r_b1, r_b2;
    hdr_t        r_hdr;
    logic        r_corr;
    logic        r_hdr_valid, r_hdr_err, r_done, r_abort;
    logic [7:0]  r_pdata;
    logic        r_pvalid, r_plast;

    logic        w_ld_b0, w_ld_b1, w_ld_b2, w_ld_hdr;
    logic        w_hdr_valid, w_hdr_err, w_done, w_abort, w_pvalid, w_plast;

    logic [23:0] w_fix_d;
    logic        w_fix_corr, w_fix_bad;
    logic        w_long;

    csi_ecc_correct u_ecc (
        .i_d             ({r_b2, r_b1, r_b0}),
        .i_ecc           (byte_data[5:0]),
        .o_d             (w_fix_d),
        .o_corrected     (w_fix_corr),
        .o_uncorrectable (w_fix_bad)
    );

    assign w_long = (w_fix_d[5:0] >= DT_LONG_MIN);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_crc_nxt   = r_crc;
        w_ld_b0     = 1'b0;
        w_ld_b1     = 1'b0;
        w_ld_b2     = 1'b0;
        w_ld_hdr    = 1'b0;
        w_hdr_valid = 1'b0;
        w_hdr_err   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_pvalid    = 1'b0;
        w_plast     = 1'b0;
        if (byte_valid) begin
            if (packet_start && r_state != ST_IDLE) begin
                // Restart header capture on this byte; the partial packet is dropped.
                w_ld_b0     = 1'b1;
                w_abort     = (r_state != ST_H1);
                w_state_nxt = ST_H1;
            end else begin
                unique case (r_state)
                    ST_IDLE: if (packet_start) begin
                        w_ld_b0     = 1'b1;
                        w_state_nxt = ST_H1;
                    end
                    ST_H1: begin
                        w_ld_b1     = 1'b1;
                        w_state_nxt = ST_H2;
                    end
                    ST_H2: begin
                        w_ld_b2     = 1'b1;
                        w_state_nxt = ST_H3;
                    end
                    ST_H3: begin
                        // WC limit only applies to long packets; short ones carry a data field.
                        if (w_fix_bad || (w_long && w_fix_d[23:8] > MAX_WC)) begin
                            w_hdr_err   = 1'b1;
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ld_hdr    = 1'b1;
                            w_hdr_valid = 1'b1;
                            if (!w_long) begin
                                w_done      = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_cnt_nxt   = w_fix_d[23:8];
                                w_crc_nxt   = 1'b0;
                                w_state_nxt = (w_fix_d[23:8] == 16'h0) ? ST_CRC : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        w_pvalid  = 1'b1;
                        w_cnt_nxt = r_cnt - 16'h1;
                        if (r_cnt == 16'h1) begin
                            w_plast     = 1'b1;
                            w_crc_nxt   = 1'b0;
                            w_state_nxt = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (r_crc) begin
                            w_done      = 1'b1;
                            w_crc_nxt   = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_crc_nxt = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_crc       <= 1'b0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_hdr       <= '0;
            r_corr      <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_pdata     <= '0;
            r_pvalid    <= 1'b0;
            r_plast     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_crc       <= w_crc_nxt;
            r_hdr_valid <= w_hdr_valid;
            r_hdr_err   <= w_hdr_err;
            r_done      <= w_done;
            r_abort     <= w_abort;
            r_pvalid    <= w_pvalid;
            r_plast     <= w_plast;
            if (w_ld_b0) r_b0 <= byte_data;
            if (w_ld_b1) r_b1 <= byte_data;
            if (w_ld_b2) r_b2 <= byte_data;
            if (w_ld_hdr) begin
                r_hdr.vc <= w_fix_d[7:6];
                r_hdr.dt <= w_fix_d[5:0];
                r_hdr.wc <= w_fix_d[23:8];
                r_corr   <= w_fix_corr;
            end
            if (w_pvalid) r_pdata <= byte_data;
        end
    end

    assign hdr_valid     = r_hdr_valid;
    assign hdr_vc        = r_hdr.vc;
    assign hdr_dt        = r_hdr.dt;
    assign hdr_wc        = r_hdr.wc;
    assign hdr_corrected = r_corr;
    assign hdr_error     = r_hdr_err;
    assign payload_data  = r_pdata;
    assign payload_valid = r_pvalid;
    assign payload_last  = r_plast;
    assign packet_done   = r_done;
    assign pkt_abort     = r_abort;

endmodule

// File: tb/tb_csi_header_decoder.sv
// Directed-vector bench for csi_header_decoder; expected values hand-computed from the CSI-2 ECC table.
module tb_csi_header_decoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        packet_start;
    logic        hdr_valid;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_corrected;
    logic        hdr_error;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_last;
    logic        packet_done;
    logic        pkt_abort;

    int n_vec = 0;
    int n_err = 0;

    csi_header_decoder #(.MAX_WC(16'h0010)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .packet_start  (packet_start),
        .hdr_valid     (hdr_valid),
        .hdr_vc        (hdr_vc),
        .hdr_dt        (hdr_dt),
        .hdr_wc        (hdr_wc),
        .hdr_corrected (hdr_corrected),
        .hdr_error     (hdr_error),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_last  (payload_last),
        .packet_done   (packet_done),
        .pkt_abort     (pkt_abort)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock per call; outputs reflecting this byte are stable on return.
    task automatic drv(input logic [7:0] b, input logic v, input logic s);
        @(negedge clock);
        byte_data    = b;
        byte_valid   = v;
        packet_start = s;
        @(posedge clock);
        #1;
    endtask

    task automatic hdr(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
        drv(b0, 1'b1, 1'b1);
        drv(b1, 1'b1, 1'b0);
        drv(b2, 1'b1, 1'b0);
        drv(b3, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] all_outs();
        return {16'h0, hdr_valid, hdr_vc, hdr_dt, hdr_corrected, hdr_error,
                payload_valid, payload_last, packet_done, pkt_abort} | {hdr_wc, payload_data, 8'h0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, lasts;
        logic act, last_final;
        reset_n = 1'b0; byte_data = '0; byte_valid = 1'b0; packet_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", all_outs(), 32'h0);
        @(negedge clock); reset_n = 1'b1;

        // Short FS header, clean
        hdr(8'h00, 8'h01, 8'h00, 8'h1A);
        chk("fs_valid", hdr_valid, 1);
        chk("fs_vc", hdr_vc, 0);
        chk("fs_dt", hdr_dt, 6'h00);
        chk("fs_wc", hdr_wc, 16'h0001);
        chk("fs_corr", hdr_corrected, 0);
        chk("fs_done", packet_done, 1);
        chk("fs_err", hdr_error, 0);
        drv(8'h00, 1'b0, 1'b0);
        chk("fs_valid_pulse", hdr_valid, 0);
        chk("fs_done_pulse", packet_done, 0);
        chk("fs_wc_hold", hdr_wc, 16'h0001);

        // Data bit 9 flipped
        hdr(8'h00, 8'h03, 8'h00, 8'h1A);
        chk("d9_valid", hdr_valid, 1);
        chk("d9_wc", hdr_wc, 16'h0001);
        chk("d9_corr", hdr_corrected, 1);

        // ECC bit 0 flipped
        hdr(8'h00, 8'h01, 8'h00, 8'h1B);
        chk("e0_valid", hdr_valid, 1);
        chk("e0_wc", hdr_wc, 16'h0001);
        chk("e0_corr", hdr_corrected, 1);

        // Double error: uncorrectable
        hdr(8'h03, 8'h01, 8'h00, 8'h1A);
        chk("dbl_err", hdr_error, 1);
        chk("dbl_done", packet_done, 1);
        chk("dbl_valid", hdr_valid, 0);
        act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv(8'h2B + 8'(i), 1'b1, 1'b0);
            act = act | hdr_valid | hdr_error | payload_valid | packet_done | pkt_abort;
        end
        chk("dbl_ignored", act, 0);

        // Long RAW10, WC 4, with valid gaps
        hdr(8'h2B, 8'h04, 8'h00, 8'h34);
        chk("raw_valid", hdr_valid, 1);
        chk("raw_dt", hdr_dt, 6'h2B);
        chk("raw_wc", hdr_wc, 16'h0004);
        chk("raw_corr", hdr_corrected, 0);
        chk("raw_done_early", packet_done, 0);
        drv(8'hA1, 1'b1, 1'b0);
        chk("raw_p0", {payload_valid, payload_last, payload_data}, {2'b10, 8'hA1});
        drv(8'h00, 1'b0, 1'b0);
        chk("raw_gap0", {payload_valid, payload_data}, {1'b0, 8'hA1});
        drv(8'hB2, 1'b1, 1'b0);
        chk("raw_p1", {payload_valid, payload_last, payload_data}, {2'b10, 8'hB2});
        drv(8'hC3, 1'b1, 1'b0);
        chk("raw_p2", {payload_valid, payload_last, payload_data}, {2'b10, 8'hC3});
        drv(8'h00, 1'b0, 1'b0);
        chk("raw_gap1", payload_valid, 0);
        drv(8'hD4, 1'b1, 1'b0);
        chk("raw_p3", {payload_valid, payload_last, payload_data}, {2'b11, 8'hD4});
        drv(8'hEE, 1'b1, 1'b0);
        chk("raw_crc0", {payload_valid, packet_done}, 2'b00);
        drv(8'h00, 1'b0, 1'b0);
        chk("raw_crc_gap", packet_done, 0);
        drv(8'hFF, 1'b1, 1'b0);
        chk("raw_done", {payload_valid, packet_done}, 2'b01);
        drv(8'h00, 1'b0, 1'b0);
        chk("raw_done_pulse", packet_done, 0);

        // Long packet, WC 0
        hdr(8'h2B, 8'h00, 8'h00, 8'h17);
        chk("wc0_valid", hdr_valid, 1);
        chk("wc0_wc", hdr_wc, 16'h0000);
        drv(8'h11, 1'b1, 1'b0);
        chk("wc0_crc0", {payload_valid, packet_done}, 2'b00);
        drv(8'h22, 1'b1, 1'b0);
        chk("wc0_done", {payload_valid, packet_done}, 2'b01);

        // packet_start during PAYLOAD
        hdr(8'h2B, 8'h04, 8'h00, 8'h34);
        drv(8'h11, 1'b1, 1'b0);
        drv(8'h22, 1'b1, 1'b0);
        drv(8'h41, 1'b1, 1'b1);
        chk("abt_pulse", pkt_abort, 1);
        chk("abt_noload", {payload_valid, payload_last}, 2'b00);
        drv(8'h05, 1'b1, 1'b0);
        chk("abt_pulse_end", pkt_abort, 0);
        drv(8'h00, 1'b1, 1'b0);
        drv(8'h28, 1'b1, 1'b0);
        chk("abt_new_hdr", {hdr_valid, hdr_vc, hdr_dt, hdr_wc, packet_done},
            {1'b1, 2'd1, 6'h01, 16'h0005, 1'b1});

        // WC above MAX_WC (0x10) rejected; WC == MAX_WC accepted
        hdr(8'h2B, 8'h11, 8'h00, 8'h2B);
        chk("max_err", {hdr_error, hdr_valid, packet_done}, 3'b101);
        hdr(8'h2B, 8'h10, 8'h00, 8'h31);
        chk("max_ok", {hdr_valid, hdr_error, hdr_wc}, {2'b10, 16'h0010});
        beats = 0; lasts = 0; last_final = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drv(8'(i), 1'b1, 1'b0);
            if (payload_valid) beats++;
            if (payload_last) lasts++;
            if (i == 15) last_final = payload_last;
        end
        chk("max_beats", beats, 16);
        chk("max_lasts", lasts, 1);
        chk("max_last_pos", last_final, 1);
        drv(8'hAA, 1'b1, 1'b0);
        drv(8'hBB, 1'b1, 1'b0);
        chk("max_done", packet_done, 1);

        // Reset mid-payload
        hdr(8'h2B, 8'h04, 8'h00, 8'h34);
        drv(8'h55, 1'b1, 1'b0);
        chk("rst_pre", {payload_valid, payload_data}, {1'b1, 8'h55});
        #2 reset_n = 1'b0;
        #1 chk("rst_async", all_outs(), 32'h0);
        @(negedge clock); reset_n = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(8'h66, 1'b1, 1'b0);
            act = act | hdr_valid | hdr_error | payload_valid | packet_done | pkt_abort;
        end
        chk("rst_idle", act, 0);
        hdr(8'h00, 8'h01, 8'h00, 8'h1A);
        chk("rst_recover", {hdr_valid, hdr_wc, packet_done}, {1'b1, 16'h0001, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
